// File: rtl/ap_pkg.sv
// Shared defaults, FSM state encoding and a parity helper for the output collector.
package ap_pkg;

  localparam int AP_OUTPORT_DEF    = 8;
  localparam int AP_N_CORE_DEF     = 8;
  localparam int AP_FIFO_DEPTH_DEF = 4;
  localparam int AP_ADDR_W_DEF     = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } ap_state_e;

  // Even parity of a lane; lanes wider than 32 bits are not supported by this helper.
  function automatic logic ap_even_par(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/ap_oc_fifo.sv
// Synchronous FIFO with registered full/empty flags; a push into a full FIFO
// is accepted when a pop happens in the same cycle.
module ap_oc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok_s, pop_ok_s;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + AW'(1);
    end
  endfunction

  // Next-state for storage, pointers, occupancy and flags.
  always_comb begin
    pop_ok_s  = pop && !empty_q;
    push_ok_s = push && (!full_q || pop_ok_s);
    mem_d     = mem_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    full_d  = (cnt_d == CW'(DEPTH));
    empty_d = (cnt_d == CW'(0));
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;

endmodule

// File: rtl/ap_out_collector.sv
// Merges per-core result strobes into packed words and streams them out with
// addresses. Optional per-lane parity output wr_par: define AP_OUT_COLLECTOR_PARITY_EN.
module ap_out_collector
  import ap_pkg::*;
#(
  parameter int outport    = AP_OUTPORT_DEF,
  parameter int N_core     = AP_N_CORE_DEF,
  parameter int FIFO_DEPTH = AP_FIFO_DEPTH_DEF,
  parameter int ADDR_W     = AP_ADDR_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [ADDR_W-1:0]         n_words,
  input  logic [outport*N_core-1:0] in_data,
  input  logic [N_core-1:0]         in_en,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic [outport*N_core-1:0] wr_data,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic                      busy,
  output logic                      done,
`ifdef AP_OUT_COLLECTOR_PARITY_EN
  output logic [N_core-1:0]         wr_par,
`endif
  output logic                      overflow
);

  localparam int DW = outport * N_core;
`ifdef AP_OUT_COLLECTOR_PARITY_EN
  localparam int FW = DW + ADDR_W + N_core;
`else
  localparam int FW = DW + ADDR_W;
`endif

  ap_state_e         state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] nwords_q, nwords_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [N_core-1:0] mask_q, mask_d;
  logic [DW-1:0]     hold_q, hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;

  logic [DW-1:0]     merged_s;
  logic              capture_s, complete_s, pop_s;
  logic [FW-1:0]     fifo_wdata_s, fifo_rdata_s;
  logic              fifo_full_s, fifo_empty_s;

  // Lane merge: bit j of in_en pairs with in_data[outport*j +: outport].
  always_comb begin
    merged_s = hold_q;
    for (int j = 0; j < N_core; j++) begin
      if (in_en[j]) begin
        merged_s[outport*j +: outport] = in_data[outport*j +: outport];
      end else begin
        merged_s[outport*j +: outport] = hold_q[outport*j +: outport];
      end
    end
  end

  assign pop_s      = !fifo_empty_s && wr_ready;
  assign capture_s  = (state_q == COLLECT) && (count_q != nwords_q);
  assign complete_s = capture_s && (&(mask_q | in_en));

`ifdef AP_OUT_COLLECTOR_PARITY_EN
  logic [N_core-1:0] par_s;

  // Per-lane even parity, carried through the FIFO alongside the word.
  always_comb begin
    par_s = '0;
    for (int j = 0; j < N_core; j++) begin
      par_s[j] = ap_even_par(32'(merged_s[outport*j +: outport]));
    end
  end

  assign fifo_wdata_s = {par_s, base_q + count_q, merged_s};
`else
  assign fifo_wdata_s = {base_q + count_q, merged_s};
`endif

  // Control FSM and collection datapath next-state.
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    nwords_d = nwords_q;
    count_d  = count_q;
    mask_d   = mask_q;
    hold_d   = hold_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = COLLECT;
          base_d   = base_addr;
          nwords_d = n_words;
          count_d  = '0;
          mask_d   = '0;
          ovf_d    = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        if (!capture_s) begin
          state_d = DRAIN;
        end else if (complete_s) begin
          hold_d  = merged_s;
          mask_d  = '0;
          count_d = count_q + ADDR_W'(1);
          // A word arriving at a full FIFO with no pop is lost but still consumes its address.
          if (fifo_full_s && !pop_s) begin
            ovf_d = 1'b1;
          end else begin
            ovf_d = ovf_q;
          end
        end else begin
          hold_d = merged_s;
          mask_d = mask_q | in_en;
        end
      end
      DRAIN: begin
        if (fifo_empty_s) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == COLLECT) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      base_q   <= '0;
      nwords_q <= '0;
      count_q  <= '0;
      mask_q   <= '0;
      hold_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      nwords_q <= nwords_d;
      count_q  <= count_d;
      mask_q   <= mask_d;
      hold_q   <= hold_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  ap_oc_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (complete_s),
    .push_data (fifo_wdata_s),
    .pop       (pop_s),
    .pop_data  (fifo_rdata_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Output word is forced to zero whenever nothing valid is presented.
  always_comb begin
    if (fifo_empty_s) begin
      wr_data = '0;
      wr_addr = '0;
    end else begin
      wr_data = fifo_rdata_s[DW-1:0];
      wr_addr = fifo_rdata_s[DW +: ADDR_W];
    end
  end

`ifdef AP_OUT_COLLECTOR_PARITY_EN
  assign wr_par = fifo_empty_s ? '0 : fifo_rdata_s[DW+ADDR_W +: N_core];
`endif

  assign wr_valid = !fifo_empty_s;
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_ap_out_collector.sv
// Scoreboard bench for ap_out_collector: expected writes are queued as words are driven.
module tb_ap_out_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [11:0] base_addr = 12'h000;
  logic [11:0] n_words = 12'h000;
  logic [63:0] in_data = 64'h0;
  logic [7:0]  in_en = 8'h00;
  logic        wr_ready = 1'b0;
  logic        wr_valid;
  logic [63:0] wr_data;
  logic [11:0] wr_addr;
  logic        busy;
  logic        done;
  logic        overflow;
`ifdef AP_OUT_COLLECTOR_PARITY_EN
  logic [7:0]  wr_par;
`endif

  int checks = 0;
  int errors = 0;
  int nwrites = 0;
  logic [75:0] exp_q[$];

  always #5 clk = ~clk;

  ap_out_collector dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .n_words   (n_words),
    .in_data   (in_data),
    .in_en     (in_en),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .wr_addr   (wr_addr),
    .busy      (busy),
    .done      (done),
`ifdef AP_OUT_COLLECTOR_PARITY_EN
    .wr_par    (wr_par),
`endif
    .overflow  (overflow)
  );

  // One clock cycle: compare any transfer at the falling edge, then step past the rising edge.
  task automatic tick();
    logic [75:0] e;
    logic [7:0]  ep;
    @(negedge clk);
    if (wr_valid && wr_ready) begin
      nwrites++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected got addr=%h data=%h, required no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          errors++;
          $display("FAIL write_word got addr=%h data=%h, required addr=%h data=%h",
                   wr_addr, wr_data, e[75:64], e[63:0]);
        end
`ifdef AP_OUT_COLLECTOR_PARITY_EN
        for (int j = 0; j < 8; j++) ep[j] = ^e[8*j +: 8];
        checks++;
        if (wr_par !== ep) begin
          errors++;
          $display("FAIL write_parity got %h, required %h", wr_par, ep);
        end
`else
        ep = 8'h00;
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [11:0] base, input logic [11:0] n);
    start = 1'b1;
    base_addr = base;
    n_words = n;
    tick();
    start = 1'b0;
  endtask

  task automatic drive(input logic [7:0] en, input logic [63:0] data);
    in_en = en;
    in_data = data;
    tick();
    in_en = 8'h00;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (done === 1'b1) seen = 1'b1;
      tick();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done got no done pulse within 60 cycles, required done=1", name);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending got %0d words unwritten, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({wr_valid, wr_data, wr_addr, busy, done, overflow} !== 80'h0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b data=%h addr=%h busy=%b done=%b ovf=%b, required all 0",
               wr_valid, wr_data, wr_addr, busy, done, overflow);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_idle_ignore();
    wr_ready = 1'b1;
    for (int i = 0; i < 3; i++) drive(8'hFF, 64'hDEADBEEF_CAFEF00D + 64'(i));
    tick();
    checks++;
    if (busy !== 1'b0 || wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_ignore got busy=%b valid=%b, required 0 0", busy, wr_valid);
    end
  endtask

  task automatic test_all_lanes();
    int w0 = nwrites;
    wr_ready = 1'b1;
    start_run(12'h100, 12'd2);
    exp_q.push_back({12'h100, 64'h0102030405060708});
    drive(8'hFF, 64'h0102030405060708);
    exp_q.push_back({12'h101, 64'h1111111111111111});
    drive(8'hFF, 64'h1111111111111111);
    wait_done("all_lanes");
    checks++;
    if (nwrites - w0 != 2 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL all_lanes_count got writes=%0d ovf=%b, required 2 0", nwrites - w0, overflow);
    end
  endtask

  task automatic test_staggered();
    wr_ready = 1'b1;
    start_run(12'h020, 12'd2);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL staggered_busy got %b, required 1", busy);
    end
    drive(8'hF0, 64'hA1A2A3A4_FFFFFFFF);
    drive(8'h0C, 64'h55555555_B1B25555);
    exp_q.push_back({12'h020, 64'hA1A2A3A4_B1B2C1C2});
    in_en = 8'h03;
    in_data = 64'h77777777_7777C1C2;
    checks++;
    if (wr_valid !== 1'b0) begin
      errors++;
      $display("FAIL staggered_early_valid got %b, required 0", wr_valid);
    end
    tick();
    in_en = 8'h00;
    checks++;
    if (wr_valid !== 1'b1) begin
      errors++;
      $display("FAIL staggered_latency got valid=%b, required 1", wr_valid);
    end
    drive(8'h81, 64'h11000000_00000022);
    drive(8'h80, 64'hEE000000_00000000);
    exp_q.push_back({12'h021, 64'hEE334455_66778822});
    drive(8'h7E, 64'h00334455_66778800);
    wait_done("staggered");
  endtask

  task automatic test_backpressure();
    int w0 = nwrites;
    wr_ready = 1'b0;
    start_run(12'h200, 12'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < 4) exp_q.push_back({12'h200 + 12'(k), {8{8'h30 + 8'(k)}}});
      drive(8'hFF, {8{8'h30 + 8'(k)}});
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL bp_overflow got %b, required 1", overflow);
    end
    tick();
    tick();
    checks++;
    if (wr_valid !== 1'b1 || wr_addr !== 12'h200 || wr_data !== {8{8'h30}}) begin
      errors++;
      $display("FAIL bp_hold got valid=%b addr=%h data=%h, required 1 200 %h",
               wr_valid, wr_addr, wr_data, {8{8'h30}});
    end
    wr_ready = 1'b1;
    wait_done("backpressure");
    checks++;
    if (nwrites - w0 != 4 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL bp_count got writes=%0d ovf=%b, required 4 1", nwrites - w0, overflow);
    end
  endtask

  task automatic test_full_push_pop();
    int w0 = nwrites;
    wr_ready = 1'b0;
    start_run(12'h300, 12'd6);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL start_clears_ovf got %b, required 0", overflow);
    end
    for (int k = 0; k < 6; k++) begin
      if (k == 4) wr_ready = 1'b1;
      exp_q.push_back({12'h300 + 12'(k), {4{8'h60 + 8'(k), 8'h9F}}});
      drive(8'hFF, {4{8'h60 + 8'(k), 8'h9F}});
    end
    wait_done("full_push_pop");
    checks++;
    if (nwrites - w0 != 6 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_push_pop_count got writes=%0d ovf=%b, required 6 0", nwrites - w0, overflow);
    end
  endtask

  task automatic test_wrap();
    wr_ready = 1'b1;
    start_run(12'hFFF, 12'd2);
    exp_q.push_back({12'hFFF, 64'h0F0E0D0C0B0A0908});
    drive(8'hFF, 64'h0F0E0D0C0B0A0908);
    exp_q.push_back({12'h000, 64'h8877665544332211});
    drive(8'hFF, 64'h8877665544332211);
    wait_done("wrap");
  endtask

  task automatic test_zero_words();
    logic [3:0] seen_done;
    int w0 = nwrites;
    wr_ready = 1'b1;
    start = 1'b1;
    base_addr = 12'h050;
    n_words = 12'd0;
    for (int c = 0; c < 4; c++) begin
      seen_done[c] = done;
      tick();
      start = 1'b0;
      if (c == 0) in_en = 8'hFF;
    end
    in_en = 8'h00;
    seen_done[0] = seen_done[0] | done;
    checks++;
    if (seen_done !== 4'b1000) begin
      errors++;
      $display("FAIL zero_words_done got done cycles 0..3 (bit per cycle, cycle 0 lsb)=%b, required 1000", seen_done);
    end
    checks++;
    if (nwrites != w0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_words_writes got writes=%0d busy=%b, required 0 0", nwrites - w0, busy);
    end
  endtask

  task automatic test_start_ignored();
    wr_ready = 1'b1;
    start_run(12'h400, 12'd1);
    start = 1'b1;
    base_addr = 12'h700;
    n_words = 12'd3;
    tick();
    start = 1'b0;
    exp_q.push_back({12'h400, 64'h0123456789ABCDEF});
    drive(8'hFF, 64'h0123456789ABCDEF);
    wait_done("start_ignored");
  endtask

  task automatic test_async_reset();
    wr_ready = 1'b0;
    start_run(12'h500, 12'd3);
    drive(8'hFF, 64'hAAAA5555AAAA5555);
    drive(8'hFF, 64'h5555AAAA5555AAAA);
    checks++;
    if (wr_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL arst_prebuffer got valid=%b busy=%b, required 1 1", wr_valid, busy);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({wr_valid, wr_data, wr_addr, busy, done, overflow} !== 80'h0) begin
      errors++;
      $display("FAIL arst_outputs got valid=%b data=%h addr=%h busy=%b done=%b ovf=%b, required all 0",
               wr_valid, wr_data, wr_addr, busy, done, overflow);
    end
    wr_ready = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (wr_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL arst_after got valid=%b busy=%b, required 0 0", wr_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_idle_ignore();
    test_all_lanes();
    test_staggered();
    test_backpressure();
    test_full_push_pop();
    test_wrap();
    test_zero_words();
    test_start_ignored();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
